mul_pipe_ctrl: RTL and testbench
================================

MUL_PIPE_CTRL -- requirements
Module: mul_pipe_ctrl

Interface
REQ-001 SHALL take parameter TAG_W, default 3, the width of the requester tag carried with each multiply.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req_valid  in  2  and req_ready  out  2: one valid/ready pair per requester (bit 0 = requester A, bit 1 = requester B).
REQ-005 SHALL have port req_tag  in  2*TAG_W  with requester A at [TAG_W-1:0] and requester B above it.
REQ-006 SHALL have port op_sel  out  1  operand mux select for the step-1 input (0 = A, 1 = B); valid whenever any req_ready bit is high.
REQ-007 SHALL have port stage_en  out  3  load enables for datapath steps 1, 2 and 3 (bit 0 = step 1).
REQ-008 SHALL have ports dp_ovf  in  1  and dp_unf  in  1: exponent overflow/underflow from the step-2 adder, sampled when stage_en[2] is high.
REQ-009 SHALL have ports resp_valid  out  1, resp_ready  in  1, resp_src  out  1, resp_tag  out  TAG_W, resp_ovf  out  1 and resp_unf  out  1, forming the result handshake and its sideband.
REQ-010 SHALL have ports flush  in  1, flag_clr  in  1, sticky_ovf  out  1, sticky_unf  out  1 and inflight  out  2.

Function
REQ-011 SHALL keep valid bits v1, v2 and v3, one per pipeline stage, each stage holding src, tag and (stage 3 only) ovf/unf.
REQ-012 SHALL compute stage_en[2] = v2 & (~v3 | resp_ready); stage_en[1] = v1 & (~v2 | stage_en[2]); stage_en[0] = accept.
REQ-013 SHALL set can_accept = ~flush & (~v1 | stage_en[1]); accept = can_accept & (any req_valid).
REQ-014 SHALL arbitrate round-robin: the priority pointer favours the requester not granted last; a lone requester is granted regardless of the pointer.
REQ-015 SHALL drive at most one req_ready bit high, and only for the granted requester when can_accept is high; req_ready SHALL NOT depend on the other requester's valid except through arbitration.
REQ-016 SHALL toggle the pointer only on a cycle where a grant is taken.
REQ-017 SHALL produce resp_valid exactly 3 cycles after acceptance when never stalled, and sustain one result per cycle while resp_ready stays high.
REQ-018 SHALL hold resp_valid, resp_src, resp_tag, resp_ovf and resp_unf stable while resp_valid & ~resp_ready, and stall upstream stages only as far as the bubbles allow.
REQ-019 SHALL latch dp_ovf and dp_unf into stage 3 on stage_en[2].
REQ-020 SHALL set sticky_ovf and sticky_unf on a resp_valid & resp_ready handshake with the corresponding bit set.
REQ-021 SHALL clear the sticky flags on flag_clr; when a clear and a set occur in the same cycle, the set wins.
REQ-022 SHALL, on flush, clear v1, v2 and v3 at the next edge, take no request that cycle, and leave the sticky flags untouched.
REQ-023 SHALL, when flush coincides with a resp handshake, still count that response as delivered, including its sticky update.
REQ-024 SHALL drive inflight = v1 + v2 + v3 (0..3), registered-state based.

Reset
REQ-025 SHALL, on rst, clear v1, v2, v3, the sticky flags and the pointer (A favoured).
REQ-026 SHALL, with rst high, drive req_ready = 0, stage_en = 0, resp_valid = 0, inflight = 0 and sticky_ovf = sticky_unf = 0.
REQ-027 SHALL give rst priority over flush, flag_clr and all handshakes; reset mid-operation discards in-flight ops without a response.

Verification
REQ-028 Single op: A valid with tag 5 at cycle 0, resp_ready = 1 -> resp_valid at cycle 3 with src = 0, tag = 5, inflight = 1, 1, 1, then 0.
REQ-029 Contention: A and B both valid for 4 cycles -> grants A, B, A, B; responses arrive in the same order on consecutive cycles.
REQ-030 Backpressure: 4 back-to-back ops with resp_ready = 0 -> pipe fills, inflight = 3, req_ready drops; release -> 4 responses in order, none lost or duplicated.
REQ-031 Flags: dp_ovf = 1 at step 2 of op 2 -> resp_ovf = 1 only on op 2, sticky_ovf set after its handshake; flag_clr in the same cycle as the handshake -> sticky_ovf stays 1.
REQ-032 Flush/reset: flush with 3 ops in flight -> next cycle inflight = 0, no resp_valid; rst asserted mid-stall -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mul_pipe_ctrl.sv
// Control for a three-step multiply datapath: two-requester round-robin intake,
// per-step load enables with bubble-collapsing stalls, result handshake and sticky exception flags.
module mul_pipe_ctrl #(
  parameter int unsigned TAG_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic                 op_sel,
  output logic [2:0]           stage_en,
  input  logic                 dp_ovf,
  input  logic                 dp_unf,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_src,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 resp_ovf,
  output logic                 resp_unf,
  input  logic                 flush,
  input  logic                 flag_clr,
  output logic                 sticky_ovf,
  output logic                 sticky_unf,
  output logic [1:0]           inflight
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e             ptr_q, ptr_d;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             v3_q, v3_d;
  logic             src1_q, src1_d;
  logic             src2_q, src2_d;
  logic             src3_q, src3_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  logic             ovf3_q, ovf3_d;
  logic             unf3_q, unf3_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_unf_q, sticky_unf_d;

  logic             en1, en2;
  logic             can_accept;
  logic             accept;
  logic             grant_b;
  logic             resp_hs;
  logic [TAG_W-1:0] tag_a, tag_b;

  assign tag_a = req_tag[TAG_W-1:0];
  assign tag_b = req_tag[2*TAG_W-1:TAG_W];

  // Advance enables: a step loads when its successor is empty or draining this cycle.
  always_comb begin
    en2        = v2_q & (~v3_q | resp_ready);
    en1        = v1_q & (~v2_q | en2);
    can_accept = ~flush & (~v1_q | en1);
    grant_b    = req_valid[1] & (~req_valid[0] | (ptr_q == PTR_B));
    accept     = can_accept & (|req_valid);
    resp_hs    = v3_q & resp_ready;
  end

  always_comb begin
    ptr_d        = ptr_q;
    v1_d         = accept | (v1_q & ~en1);
    v2_d         = en1 | (v2_q & ~en2);
    v3_d         = en2 | (v3_q & ~resp_ready);
    src1_d       = src1_q;
    tag1_d       = tag1_q;
    src2_d       = src2_q;
    tag2_d       = tag2_q;
    src3_d       = src3_q;
    tag3_d       = tag3_q;
    ovf3_d       = ovf3_q;
    unf3_d       = unf3_q;
    sticky_ovf_d = (resp_hs & ovf3_q) | (sticky_ovf_q & ~flag_clr);
    sticky_unf_d = (resp_hs & unf3_q) | (sticky_unf_q & ~flag_clr);

    if (accept) begin
      src1_d = grant_b;
      tag1_d = grant_b ? tag_b : tag_a;
      ptr_d  = grant_b ? PTR_A : PTR_B;
    end
    if (en1) begin
      src2_d = src1_q;
      tag2_d = tag1_q;
    end
    if (en2) begin
      src3_d = src2_q;
      tag3_d = tag2_q;
      ovf3_d = dp_ovf;
      unf3_d = dp_unf;
    end

    // Flush empties the pipe but a response delivered this cycle still updates the flags above.
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= PTR_A;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      src1_q       <= 1'b0;
      src2_q       <= 1'b0;
      src3_q       <= 1'b0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      tag3_q       <= '0;
      ovf3_q       <= 1'b0;
      unf3_q       <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      src3_q       <= src3_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      tag3_q       <= tag3_d;
      ovf3_q       <= ovf3_d;
      unf3_q       <= unf3_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  // Outputs are forced idle while reset is held, even before the first reset edge.
  always_comb begin
    req_ready  = 2'b00;
    if (accept && !rst) begin
      req_ready = grant_b ? 2'b10 : 2'b01;
    end
    op_sel     = grant_b;
    stage_en   = rst ? 3'b000 : {en2, en1, accept};
    resp_valid = v3_q & ~rst;
    resp_src   = src3_q;
    resp_tag   = tag3_q;
    resp_ovf   = ovf3_q;
    resp_unf   = unf3_q;
    sticky_ovf = sticky_ovf_q & ~rst;
    sticky_unf = sticky_unf_q & ~rst;
    inflight   = rst ? 2'd0 : ({1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q});
  end

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: scenario tasks plus a response scoreboard.
module tb_mul_pipe_ctrl;
  localparam int unsigned TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*TAG_W-1:0] req_tag;
  logic             op_sel;
  logic [2:0]       stage_en;
  logic             dp_ovf, dp_unf;
  logic             resp_valid, resp_ready, resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_ovf, resp_unf;
  logic             flush, flag_clr;
  logic             sticky_ovf, sticky_unf;
  logic [1:0]       inflight;

  // expected entry: {src, tag, ovf, unf}
  typedef logic [TAG_W+2:0] exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic             hold_pend = 1'b0;
  logic             h_src, h_ovf, h_unf;
  logic [TAG_W-1:0] h_tag;

  mul_pipe_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .op_sel(op_sel), .stage_en(stage_en),
    .dp_ovf(dp_ovf), .dp_unf(dp_unf), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_src(resp_src), .resp_tag(resp_tag),
    .resp_ovf(resp_ovf), .resp_unf(resp_unf), .flush(flush),
    .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Scoreboard pop on every delivered response, plus hold-stability during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_checks++;
        if (resp_valid !== 1'b1 || resp_src !== h_src || resp_tag !== h_tag ||
            resp_ovf !== h_ovf || resp_unf !== h_unf) begin
          n_fail++;
          $display("FAIL resp_hold: got v=%b src=%b tag=%0d ovf=%b unf=%b, need v=1 src=%b tag=%0d ovf=%b unf=%b",
                   resp_valid, resp_src, resp_tag, resp_ovf, resp_unf, h_src, h_tag, h_ovf, h_unf);
        end
      end
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got src=%b tag=%0d, need no response", resp_src, resp_tag);
        end else begin
          e = sb.pop_front();
          if ({resp_src, resp_tag, resp_ovf, resp_unf} !== e) begin
            n_fail++;
            $display("FAIL resp_data: got {src,tag,ovf,unf}=%b_%0d_%b_%b, need %b_%0d_%b_%b",
                     resp_src, resp_tag, resp_ovf, resp_unf,
                     e[TAG_W+2], e[TAG_W+1:2], e[1], e[0]);
          end
        end
      end
      hold_pend = resp_valid && !resp_ready && !flush;
      h_src = resp_src;
      h_tag = resp_tag;
      h_ovf = resp_ovf;
      h_unf = resp_unf;
    end
  end

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11; req_tag = {3'd6, 3'd2}; resp_ready = 1'b1;
    next(); next();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00 || stage_en !== 3'b000 || resp_valid !== 1'b0 ||
        inflight !== 2'd0 || sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rr=%b se=%b rv=%b inf=%0d so=%b su=%b, need all zero",
               req_ready, stage_en, resp_valid, inflight, sticky_ovf, sticky_unf);
    end
    next();
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single;
    logic [1:0] exp_inf [5];
    exp_inf = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    req_valid = 2'b01; req_tag = {3'd0, 3'd5};
    sb.push_back({1'b0, 3'd5, 1'b0, 1'b0});
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01 || stage_en !== 3'b001 || op_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got rr=%b se=%b sel=%b, need 01 001 0", req_ready, stage_en, op_sel);
    end
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      n_checks++;
      if (inflight !== exp_inf[t] || resp_valid !== (t == 3)) begin
        n_fail++;
        $display("FAIL single_cycle%0d: got inf=%0d rv=%b, need inf=%0d rv=%b",
                 t, inflight, resp_valid, exp_inf[t], (t == 3));
      end
      if (t == 3) begin
        n_checks++;
        if (resp_tag !== 3'd5 || resp_src !== 1'b0) begin
          n_fail++;
          $display("FAIL single_resp: got src=%b tag=%0d, need 0 5", resp_src, resp_tag);
        end
      end
      next();
      req_valid = 2'b00;
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_rr;
    rst = 1'b1; next(); rst = 1'b0;
    resp_ready = 1'b1;
    req_valid = 2'b11; req_tag = {3'd6, 3'd2};
    for (int t = 0; t < 8; t++) begin
      if (t < 4) begin
        exp_rr = (t % 2 == 0) ? 2'b01 : 2'b10;
        if (t % 2 == 0) sb.push_back({1'b0, 3'd2, 1'b0, 1'b0});
        else            sb.push_back({1'b1, 3'd6, 1'b0, 1'b0});
      end
      @(negedge clk);
      if (t < 4) begin
        n_checks++;
        if (req_ready !== exp_rr || op_sel !== exp_rr[1]) begin
          n_fail++;
          $display("FAIL contention_grant%0d: got rr=%b sel=%b, need rr=%b", t, req_ready, op_sel, exp_rr);
        end
      end
      if (t >= 3) begin
        n_checks++;
        if (resp_valid !== (t < 7)) begin
          n_fail++;
          $display("FAIL contention_resp%0d: got rv=%b, need %b", t, resp_valid, (t < 7));
        end
      end
      next();
      if (t == 3) req_valid = 2'b00;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL contention_drain: got %0d pending, need 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    int budget;
    resp_ready = 1'b0;
    req_valid = 2'b01;
    for (int t = 0; t < 7; t++) begin
      req_tag = {3'd0, 3'(t < 3 ? t + 1 : 4)};
      if (t < 3 || t == 6) sb.push_back({1'b0, 3'(t < 3 ? t + 1 : 4), 1'b0, 1'b0});
      if (t == 6) resp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== ((t < 3 || t == 6) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got rr=%b, need %b", t, req_ready, ((t < 3 || t == 6) ? 2'b01 : 2'b00));
      end
      if (t >= 3 && t < 6) begin
        n_checks++;
        if (inflight !== 2'd3 || resp_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_full%0d: got inf=%0d rv=%b, need 3 1", t, inflight, resp_valid);
        end
      end
      next();
    end
    req_valid = 2'b00;
    budget = 0;
    while (sb.size() != 0 && budget < 12) begin
      next();
      budget++;
    end
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || inflight !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got pending=%0d inf=%0d, need 0 0", sb.size(), inflight);
    end
    next();
  endtask

  task automatic test_flags;
    resp_ready = 1'b1;
    req_valid = 2'b01;
    for (int t = 0; t < 8; t++) begin
      dp_ovf = (t == 3); dp_unf = (t == 4);
      flag_clr = (t == 4 || t == 6);
      if (t < 3) begin
        req_tag = {3'd0, 3'(t + 1)};
        sb.push_back({1'b0, 3'(t + 1), (t == 1), (t == 2)});
      end else begin
        req_valid = 2'b00;
      end
      @(negedge clk);
      case (t)
        4: begin
          n_checks++;
          if (sticky_ovf !== 1'b0 || resp_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_pre: got so=%b rovf=%b, need 0 1", sticky_ovf, resp_ovf);
          end
        end
        5: begin
          n_checks++;
          if (sticky_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_set_wins: got so=%b, need 1", sticky_ovf);
          end
        end
        6: begin
          n_checks++;
          if (sticky_unf !== 1'b1 || sticky_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_unf: got so=%b su=%b, need 1 1", sticky_ovf, sticky_unf);
          end
        end
        7: begin
          n_checks++;
          if (sticky_unf !== 1'b0 || sticky_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_clr: got so=%b su=%b, need 0 0", sticky_ovf, sticky_unf);
          end
        end
        default: ;
      endcase
      next();
    end
    dp_ovf = 1'b0; dp_unf = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic test_flush;
    resp_ready = 1'b0;
    req_valid = 2'b01;
    for (int t = 0; t < 5; t++) begin
      req_tag = {3'd0, 3'(t + 1)};
      flush = (t == 3);
      @(negedge clk);
      if (t == 3) begin
        n_checks++;
        if (req_ready !== 2'b00 || inflight !== 2'd3) begin
          n_fail++;
          $display("FAIL flush_cycle: got rr=%b inf=%0d, need 00 3", req_ready, inflight);
        end
      end
      if (t == 4) begin
        req_valid = 2'b00;
        n_checks++;
        if (inflight !== 2'd0 || resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_after: got inf=%0d rv=%b, need 0 0", inflight, resp_valid);
        end
      end
      next();
    end
    flush = 1'b0;
    // flush together with a delivering handshake
    req_valid = 2'b01; req_tag = {3'd0, 3'd7};
    for (int t = 0; t < 5; t++) begin
      dp_unf = (t == 2);
      if (t == 3) begin
        resp_ready = 1'b1; flush = 1'b1;
        sb.push_back({1'b0, 3'd7, 1'b0, 1'b1});
      end
      @(negedge clk);
      if (t == 4) begin
        n_checks++;
        if (inflight !== 2'd0 || resp_valid !== 1'b0 || sticky_unf !== 1'b1 || sb.size() != 0) begin
          n_fail++;
          $display("FAIL flush_hs: got inf=%0d rv=%b su=%b pending=%0d, need 0 0 1 0",
                   inflight, resp_valid, sticky_unf, sb.size());
        end
      end
      next();
      req_valid = 2'b00;
      if (t == 3) flush = 1'b0;
    end
    dp_unf = 1'b0;
  endtask

  task automatic test_reset_mid_stall;
    resp_ready = 1'b0;
    req_valid = 2'b01;
    for (int t = 0; t < 6; t++) begin
      req_tag = {3'd0, 3'(t + 2)};
      if (t == 4) rst = 1'b1;
      if (t == 5) begin rst = 1'b0; req_valid = 2'b00; end
      @(negedge clk);
      if (t == 3) begin
        n_checks++;
        if (inflight !== 2'd3 || resp_valid !== 1'b1 || sticky_unf !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_stall_pre: got inf=%0d rv=%b su=%b, need 3 1 1", inflight, resp_valid, sticky_unf);
        end
      end
      if (t >= 4) begin
        n_checks++;
        if (req_ready !== 2'b00 || stage_en !== 3'b000 || resp_valid !== 1'b0 ||
            inflight !== 2'd0 || sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_stall%0d: got rr=%b se=%b rv=%b inf=%0d so=%b su=%b, need all zero",
                   t, req_ready, stage_en, resp_valid, inflight, sticky_ovf, sticky_unf);
        end
      end
      next();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_stall_sb: got %0d pending, need 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_tag = '0; dp_ovf = 1'b0; dp_unf = 1'b0;
    resp_ready = 1'b1; flush = 1'b0; flag_clr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flags();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "timeout");
  end

endmodule
